// File: rtl/signal_framer.sv
// signal_framer: packs a never-stalling sample stream into FRAME_LEN-sample frames, admitting whole frames
// into a first-word-fall-through FIFO. Define FRAMER_FRAME_CNT_EN to add frame_cnt/drop_cnt statistics ports.
module signal_framer #(
    parameter int DATAWIDTH  = 32,
    parameter int FRAME_LEN  = 16,
    parameter int FIFO_DEPTH = 32,
    localparam int CNTW      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic [DATAWIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sof,
    output logic                 out_eof,
    output logic [CNTW-1:0]      fifo_count,
    output logic                 overflow,
    input  logic                 clr_ovf
`ifdef FRAMER_FRAME_CNT_EN
    ,
    output logic [15:0]          frame_cnt,
    output logic [15:0]          drop_cnt
`endif
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int IDXW = $clog2(FRAME_LEN);
    localparam int EW   = DATAWIDTH + 2;

    typedef enum logic {
        S_ACCEPT = 1'b0,
        S_DROP   = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [IDXW-1:0]     r_idx;
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [CNTW-1:0]     r_count;
    logic                r_overflow;
    logic [EW-1:0]       r_mem [FIFO_DEPTH];

    logic                w_frame_start;
    logic                w_frame_last;
    logic                w_fits;
    logic [CNTW-1:0]     w_free;
    logic                w_push;
    logic                w_pop;
    logic                w_drop;
    logic [EW-1:0]       w_head;

    assign w_frame_start = (r_idx == '0);
    assign w_frame_last  = (r_idx == IDXW'(FRAME_LEN - 1));
    // Free space is judged on pre-edge occupancy; a pop in the same cycle earns no credit.
    assign w_free        = CNTW'(FIFO_DEPTH) - r_count;
    assign w_fits        = (w_free >= CNTW'(FRAME_LEN));
    assign w_pop         = (r_count != '0) && out_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_ACCEPT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: the admission decision is only taken on the first sample of a frame
    always_comb begin
        w_state_next = r_state;
        if (in_valid && w_frame_start) begin
            w_state_next = w_fits ? S_ACCEPT : S_DROP;
        end
    end

    // Outputs: the first sample of a frame already follows the fresh decision
    always_comb begin
        w_push = 1'b0;
        w_drop = 1'b0;
        if (in_valid) begin
            w_push = (w_state_next == S_ACCEPT);
            w_drop = w_frame_start && (w_state_next == S_DROP);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx      <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (in_valid) begin
                r_idx <= w_frame_last ? '0 : r_idx + 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Storage carries no reset so it maps onto plain RAM; emptiness masks stale contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_frame_start, w_frame_last, in_data};
        end
    end

    assign w_head     = r_mem[r_rd_ptr];
    assign out_valid  = (r_count != '0);
    assign out_data   = out_valid ? w_head[DATAWIDTH-1:0] : '0;
    assign out_sof    = out_valid & w_head[EW-1];
    assign out_eof    = out_valid & w_head[EW-2];
    assign fifo_count = r_count;
    assign overflow   = r_overflow;

`ifdef FRAMER_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_pop && w_head[EW-2]) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if (w_drop) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign drop_cnt  = r_drop_cnt;
`endif

    // Whole-frame admission means an accepted write can never meet a full FIFO.
    assert property (@(posedge clk) disable iff (rst)
        !(w_push && (r_count == CNTW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_signal_framer.sv
// tb_signal_framer: scoreboard bench for signal_framer; a negedge monitor predicts admission and output order.
module tb_signal_framer;

    localparam int DW    = 32;
    localparam int FL    = 16;
    localparam int DEPTH = 32;
    localparam int CNTW  = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [DW-1:0]   in_data = '0;
    logic            in_valid = 1'b0;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            out_sof;
    logic            out_eof;
    logic [CNTW-1:0] fifo_count;
    logic            overflow;
    logic            clr_ovf = 1'b0;
`ifdef FRAMER_FRAME_CNT_EN
    logic [15:0]     frame_cnt;
    logic [15:0]     drop_cnt;
`endif

    signal_framer #(
        .DATAWIDTH (DW),
        .FRAME_LEN (FL),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .fifo_count(fifo_count),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
`ifdef FRAMER_FRAME_CNT_EN
        ,
        .frame_cnt (frame_cnt),
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state, advanced once per cycle by the monitor.
    logic [DW+1:0] sb[$];
    int            m_cnt = 0;
    int            m_idx = 0;
    bit            m_acc = 1'b1;
    bit            m_ovf = 1'b0;
    int            m_frames = 0;
    int            m_drops = 0;
    int            n_pop = 0;
    int            n_sof = 0;
    int            n_eof = 0;
    int            last_eof_pop = 0;
    bit            prev_stall = 1'b0;
    logic [DW+1:0] prev_head = '0;
    logic [DW-1:0] seq = 32'h0000_1000;

    always @(negedge clk) begin
        logic [DW+1:0] exp_e;
        logic [DW+1:0] act_e;
        bit            pop;
        bit            push;
        bit            drop;
        if (rst) begin
            sb.delete();
            m_cnt = 0; m_idx = 0; m_acc = 1'b1; m_ovf = 1'b0;
            m_frames = 0; m_drops = 0; prev_stall = 1'b0;
        end else begin
            act_e = {out_sof, out_eof, out_data};
            n_cmp++;
            if (fifo_count !== CNTW'(m_cnt)) begin
                n_fail++; $display("FAIL mon_count: got %0d expected %0d at %0t", fifo_count, m_cnt, $time);
            end
            n_cmp++;
            if (out_valid !== (m_cnt != 0)) begin
                n_fail++; $display("FAIL mon_valid: got %b expected %b at %0t", out_valid, (m_cnt != 0), $time);
            end
            n_cmp++;
            if (overflow !== m_ovf) begin
                n_fail++; $display("FAIL mon_overflow: got %b expected %b at %0t", overflow, m_ovf, $time);
            end
`ifdef FRAMER_FRAME_CNT_EN
            n_cmp++;
            if (frame_cnt !== 16'(m_frames) || drop_cnt !== 16'(m_drops)) begin
                n_fail++; $display("FAIL mon_counters: got frame=%0d drop=%0d expected frame=%0d drop=%0d at %0t",
                                   frame_cnt, drop_cnt, m_frames, m_drops, $time);
            end
`endif
            if (prev_stall && out_valid) begin
                n_cmp++;
                if (act_e !== prev_head) begin
                    n_fail++; $display("FAIL mon_stall_stable: got %h expected %h at %0t", act_e, prev_head, $time);
                end
            end
            pop = (m_cnt != 0) && out_ready;
            if (pop) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL mon_pop_empty: got %h expected no output at %0t", act_e, $time);
                end else begin
                    exp_e = sb.pop_front();
                    if (act_e !== exp_e) begin
                        n_fail++; $display("FAIL mon_pop_data: got sof=%b eof=%b data=%h expected sof=%b eof=%b data=%h at %0t",
                                           out_sof, out_eof, out_data, exp_e[DW+1], exp_e[DW], exp_e[DW-1:0], $time);
                    end
                    if (exp_e[DW]) m_frames++;
                end
                n_pop++;
                if (out_sof) n_sof++;
                if (out_eof) begin
                    n_eof++;
                    last_eof_pop = n_pop;
                end
                $display("pop #%0d data=%h sof=%b eof=%b", n_pop, out_data, out_sof, out_eof);
            end
            push = 1'b0;
            drop = 1'b0;
            if (in_valid) begin
                if (m_idx == 0) begin
                    m_acc = (DEPTH - m_cnt) >= FL;
                    drop  = !m_acc;
                end
                if (m_acc) begin
                    sb.push_back({(m_idx == 0), (m_idx == FL - 1), in_data});
                    push = 1'b1;
                end
                m_idx = (m_idx == FL - 1) ? 0 : m_idx + 1;
            end
            if (drop) begin
                m_ovf = 1'b1;
                m_drops++;
            end else if (clr_ovf) begin
                m_ovf = 1'b0;
            end
            m_cnt = m_cnt + int'(push) - int'(pop);
            prev_stall = out_valid && !out_ready;
            prev_head  = act_e;
        end
    end

    // One clock of stimulus; inputs change just after the rising edge.
    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic rdy, input logic clr);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        clr_ovf   = clr;
    endtask

    task automatic send(input int n, input logic rdy);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, seq, rdy, 1'b0);
            seq = seq + 1;
        end
        cyc(1'b0, '0, rdy, 1'b0);
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (m_cnt != 0 && k < 200) begin
            cyc(1'b0, '0, 1'b1, 1'b0);
            k++;
        end
        cyc(1'b0, '0, 1'b1, 1'b0);
        n_cmp++;
        if (m_cnt != 0 || fifo_count !== '0) begin
            n_fail++; $display("FAIL %s_drain: got count %0d expected 0 within budget", tag, fifo_count);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_sof !== 1'b0 || out_eof !== 1'b0 ||
            fifo_count !== '0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: got v=%b d=%h s=%b e=%b c=%0d o=%b expected all zero",
                               out_valid, out_data, out_sof, out_eof, fifo_count, overflow);
        end
`ifdef FRAMER_FRAME_CNT_EN
        n_cmp++;
        if (frame_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
            n_fail++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", frame_cnt, drop_cnt);
        end
`endif
        $display("test_reset done");
    endtask

    task automatic test_single_frame();
        int p0, s0, e0;
        p0 = n_pop; s0 = n_sof; e0 = n_eof;
        for (int i = 0; i <= FL; i++) begin
            if (i < FL) cyc(1'b1, DW'(i), 1'b1, 1'b0);
            else        cyc(1'b0, '0, 1'b1, 1'b0);
            if (i > 0) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== DW'(i - 1)) begin
                    n_fail++; $display("FAIL single_latency: got v=%b d=%h expected v=1 d=%h", out_valid, out_data, DW'(i - 1));
                end
            end
        end
        drain("single");
        n_cmp++;
        if (n_pop - p0 != FL || n_sof - s0 != 1 || n_eof - e0 != 1 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL single_frame: got pops=%0d sof=%0d eof=%0d ovf=%b expected 16/1/1/0",
                               n_pop - p0, n_sof - s0, n_eof - e0, overflow);
        end
        $display("test_single_frame done");
    endtask

    task automatic test_overflow();
        send(2 * FL, 1'b0);
        n_cmp++;
        if (fifo_count !== CNTW'(32) || overflow !== 1'b0) begin
            n_fail++; $display("FAIL ovf_full: got count=%0d ovf=%b expected 32/0", fifo_count, overflow);
        end
        send(FL, 1'b0);
        n_cmp++;
        if (fifo_count !== CNTW'(32) || overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_drop: got count=%0d ovf=%b expected 32/1", fifo_count, overflow);
        end
        cyc(1'b0, '0, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b0);
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_fail++; $display("FAIL ovf_clear: got %b expected 0", overflow);
        end
        drain("overflow");
        $display("test_overflow done");
    endtask

    task automatic test_partial();
        int p0;
        send(24, 1'b0);
        n_cmp++;
        if (fifo_count !== CNTW'(24)) begin
            n_fail++; $display("FAIL partial_count: got %0d expected 24", fifo_count);
        end
        p0 = n_pop;
        drain("partial");
        n_cmp++;
        if (n_pop - p0 != 24 || last_eof_pop - p0 != FL) begin
            n_fail++; $display("FAIL partial_eof: got pops=%0d eof_at=%0d expected 24/16", n_pop - p0, last_eof_pop - p0);
        end
        $display("test_partial done");
    endtask

    task automatic test_gapped();
        int s0, e0, p0;
        s0 = n_sof; e0 = n_eof; p0 = n_pop;
        // 48 samples continue the frame left open by test_partial (8 of 16 already sent)
        for (int i = 0; i < 48 * 3; i++) begin
            if (i % 3 == 0) begin
                cyc(1'b1, seq, 1'($urandom_range(0, 1)), 1'b0);
                seq = seq + 1;
            end else begin
                cyc(1'b0, '0, 1'($urandom_range(0, 1)), 1'b0);
            end
        end
        drain("gapped");
        n_cmp++;
        if (n_pop - p0 != 48 || n_sof - s0 != 3 || n_eof - e0 != 3 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL gapped_frames: got pops=%0d sof=%0d eof=%0d ovf=%b expected 48/3/3/0",
                               n_pop - p0, n_sof - s0, n_eof - e0, overflow);
        end
        $display("test_gapped done");
    endtask

    task automatic test_reset_midframe();
        logic [DW-1:0] first;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, seq, 1'b0, 1'b0);
            seq = seq + 1;
        end
        @(posedge clk);
        #3;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_sof !== 1'b0 || out_eof !== 1'b0 ||
            fifo_count !== '0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL midframe_async: got v=%b d=%h c=%0d expected all zero", out_valid, out_data, fifo_count);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        first = seq;
        cyc(1'b1, seq, 1'b1, 1'b0);
        seq = seq + 1;
        cyc(1'b1, seq, 1'b1, 1'b0);
        seq = seq + 1;
        n_cmp++;
        if (out_sof !== 1'b1 || out_data !== first) begin
            n_fail++; $display("FAIL midframe_sof: got sof=%b d=%h expected sof=1 d=%h", out_sof, out_data, first);
        end
        send(FL - 2, 1'b1);
        drain("midframe");
        $display("test_reset_midframe done");
    endtask

`ifdef FRAMER_FRAME_CNT_EN
    task automatic test_counters();
        do_reset();
        send(3 * FL, 1'b0);
        drain("counters");
        n_cmp++;
        if (frame_cnt !== 16'd2 || drop_cnt !== 16'd1) begin
            n_fail++; $display("FAIL counters_value: got frame=%0d drop=%0d expected 2/1", frame_cnt, drop_cnt);
        end
        cyc(1'b0, '0, 1'b1, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        n_cmp++;
        if (frame_cnt !== 16'd2 || drop_cnt !== 16'd1 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL counters_clr: got frame=%0d drop=%0d ovf=%b expected 2/1/0", frame_cnt, drop_cnt, overflow);
        end
        $display("test_counters done");
    endtask
`endif

    task automatic test_clr_vs_drop();
        send(2 * FL, 1'b0);
        cyc(1'b1, seq, 1'b0, 1'b1);
        seq = seq + 1;
        cyc(1'b0, '0, 1'b0, 1'b0);
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_fail++; $display("FAIL clr_vs_drop: got %b expected 1", overflow);
        end
        send(FL - 1, 1'b0);
        n_cmp++;
        if (fifo_count !== CNTW'(32)) begin
            n_fail++; $display("FAIL clr_vs_drop_count: got %0d expected 32", fifo_count);
        end
        cyc(1'b0, '0, 1'b0, 1'b1);
        drain("clr_vs_drop");
        $display("test_clr_vs_drop done");
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_overflow();
        test_partial();
        test_gapped();
        test_reset_midframe();
`ifdef FRAMER_FRAME_CNT_EN
        test_counters();
`endif
        test_clr_vs_drop();
        repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL leftover_scoreboard: got %0d entries expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
